// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset datapath (IF/ID/EX/MEM/WB sequencing).
// Define MC_PERF_CNT_EN to add the cycle_cnt / instret_cnt performance counters.
module multi_cycle_ctrl #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      OPcode,
    input  logic [2:0]      Fun3,
    input  logic            Fun7,
    input  logic            zero,
    input  logic            blt,
    input  logic            MIO_ready,
    output logic            PCEN,
    output logic [1:0]      PCSource,
    output logic            IorD,
    output logic            IRWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            CPU_MIO,
    output logic [1:0]      ALUSrc_A,
    output logic [1:0]      ALUSrc_B,
    output logic [2:0]      ImmSel,
    output logic [2:0]      ALUC,
    output logic            Sign,
    output logic [1:0]      DatatoReg,
    output logic            RegWrite,
    output logic [ST_W-1:0] state
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instret_cnt
`endif
);

    typedef enum logic [ST_W-1:0] {
        ST_IF, ST_ID, ST_EX_R, ST_EX_I, ST_EX_MA, ST_MEM_RD, ST_MEM_WR,
        ST_WB_R, ST_WB_LD, ST_EX_BR, ST_EX_JAL, ST_EX_JALR, ST_EX_LUI
    } state_t;

    localparam logic [4:0] OP_R    = 5'b01100;
    localparam logic [4:0] OP_I    = 5'b00100;
    localparam logic [4:0] OP_LW   = 5'b00000;
    localparam logic [4:0] OP_SW   = 5'b01000;
    localparam logic [4:0] OP_BR   = 5'b11000;
    localparam logic [4:0] OP_JAL  = 5'b11011;
    localparam logic [4:0] OP_JALR = 5'b11001;
    localparam logic [4:0] OP_LUI  = 5'b01101;

    state_t state_q, state_d;
    // Remembers whether the EX_R/EX_I funct was supported, so WB_R can suppress the write.
    logic   wb_en_q, wb_en_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IF;
            wb_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wb_en_q <= wb_en_d;
        end
    end

    always_comb begin
        state_d   = ST_IF;
        wb_en_d   = wb_en_q;
        PCEN      = 1'b0;
        PCSource  = 2'b00;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        ALUSrc_A  = 2'b00;
        ALUSrc_B  = 2'b00;
        ImmSel    = 3'b000;
        ALUC      = 3'b000;
        Sign      = 1'b0;
        DatatoReg = 2'b00;
        RegWrite  = 1'b0;
        unique case (state_q)
            ST_IF: begin
                MemRead  = 1'b1;
                ALUSrc_B = 2'b01;
                ALUC     = 3'b010;
                if (MIO_ready) begin
                    IRWrite = 1'b1;
                    PCEN    = 1'b1;
                    state_d = ST_ID;
                end
            end
            ST_ID: begin
                ALUSrc_B = 2'b10;
                ImmSel   = (OPcode == OP_JAL) ? 3'b011 : 3'b010;
                ALUC     = 3'b010;
                case (OPcode)
                    OP_R:         state_d = ST_EX_R;
                    OP_I:         state_d = ST_EX_I;
                    OP_LW, OP_SW: state_d = ST_EX_MA;
                    OP_BR:        state_d = ST_EX_BR;
                    OP_JAL:       state_d = ST_EX_JAL;
                    OP_JALR:      state_d = ST_EX_JALR;
                    OP_LUI:       state_d = ST_EX_LUI;
                    default:      state_d = ST_IF;
                endcase
            end
            ST_EX_R: begin
                ALUSrc_A = 2'b01;
                Sign     = 1'b1;
                wb_en_d  = 1'b1;
                state_d  = ST_WB_R;
                case ({Fun3, Fun7})
                    4'b0000: ALUC = 3'b010;
                    4'b0001: ALUC = 3'b110;
                    4'b1110: ALUC = 3'b000;
                    4'b1100: ALUC = 3'b001;
                    4'b0100: ALUC = 3'b111;
                    4'b0110: begin ALUC = 3'b111; Sign = 1'b0; end
                    4'b1010: ALUC = 3'b101;
                    4'b1000: ALUC = 3'b011;
                    default: begin ALUC = 3'b010; wb_en_d = 1'b0; end
                endcase
            end
            ST_EX_I: begin
                ALUSrc_A = 2'b01;
                ALUSrc_B = 2'b10;
                Sign     = 1'b1;
                wb_en_d  = 1'b1;
                state_d  = ST_WB_R;
                case (Fun3)
                    3'b000:  ALUC = 3'b010;
                    3'b111:  ALUC = 3'b000;
                    3'b110:  ALUC = 3'b001;
                    3'b010:  ALUC = 3'b111;
                    3'b011:  begin ALUC = 3'b111; Sign = 1'b0; end
                    3'b101:  ALUC = 3'b101;
                    3'b100:  ALUC = 3'b011;
                    default: begin ALUC = 3'b010; wb_en_d = 1'b0; end
                endcase
            end
            ST_EX_MA: begin
                ALUSrc_A = 2'b01;
                ALUSrc_B = 2'b10;
                ALUC     = 3'b010;
                ImmSel   = (OPcode == OP_SW) ? 3'b001 : 3'b000;
                state_d  = (OPcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = MIO_ready ? ST_WB_LD : ST_MEM_RD;
            end
            ST_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = MIO_ready ? ST_IF : ST_MEM_WR;
            end
            ST_WB_R: begin
                RegWrite = wb_en_q;
            end
            ST_WB_LD: begin
                RegWrite  = 1'b1;
                DatatoReg = 2'b01;
            end
            ST_EX_BR: begin
                ALUSrc_A = 2'b01;
                PCSource = 2'b01;
                case (Fun3)
                    3'b000:  begin ALUC = 3'b110; PCEN = zero;  end
                    3'b001:  begin ALUC = 3'b110; PCEN = ~zero; end
                    3'b100:  begin ALUC = 3'b111; Sign = 1'b1; PCEN = blt; end
                    default: PCEN = 1'b0;
                endcase
            end
            ST_EX_JAL: begin
                PCEN      = 1'b1;
                PCSource  = 2'b01;
                RegWrite  = 1'b1;
                DatatoReg = 2'b10;
            end
            ST_EX_JALR: begin
                ALUSrc_A  = 2'b01;
                ALUSrc_B  = 2'b10;
                ALUC      = 3'b010;
                PCEN      = 1'b1;
                RegWrite  = 1'b1;
                DatatoReg = 2'b10;
            end
            ST_EX_LUI: begin
                ImmSel    = 3'b100;
                RegWrite  = 1'b1;
                DatatoReg = 2'b11;
            end
            default: state_d = ST_IF;
        endcase
        // Reset silences every control output immediately, not just at the next edge.
        if (!reset) begin
            PCEN      = 1'b0;
            PCSource  = 2'b00;
            IorD      = 1'b0;
            IRWrite   = 1'b0;
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            ALUSrc_A  = 2'b00;
            ALUSrc_B  = 2'b00;
            ImmSel    = 3'b000;
            ALUC      = 3'b000;
            Sign      = 1'b0;
            DatatoReg = 2'b00;
            RegWrite  = 1'b0;
        end
        CPU_MIO = MemRead | MemWrite;
    end

    assign state = state_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + 32'd1;
        instret_cnt_d = instret_cnt_q;
        if (state_d == ST_IF && state_q != ST_IF) begin
            instret_cnt_d = instret_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: decode table, corner-case sequences, and
// randomized instructions checked against an instruction-level latency/effect model.
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] OPcode = '0;
    logic [2:0] Fun3 = '0;
    logic       Fun7 = 1'b0, zero = 1'b0, blt = 1'b0, MIO_ready = 1'b0;
    logic       PCEN, IorD, IRWrite, MemRead, MemWrite, CPU_MIO, Sign, RegWrite;
    logic [1:0] PCSource, ALUSrc_A, ALUSrc_B, DatatoReg;
    logic [2:0] ImmSel, ALUC;
    logic [3:0] state;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multi_cycle_ctrl #(.ST_W(4)) dut (
        .clk(clk), .reset(reset), .OPcode(OPcode), .Fun3(Fun3), .Fun7(Fun7),
        .zero(zero), .blt(blt), .MIO_ready(MIO_ready), .PCEN(PCEN), .PCSource(PCSource),
        .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .CPU_MIO(CPU_MIO), .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B), .ImmSel(ImmSel),
        .ALUC(ALUC), .Sign(Sign), .DatatoReg(DatatoReg), .RegWrite(RegWrite), .state(state)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Leaves the bench just after a falling edge, reset released, DUT in IF.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        MIO_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [4:0] op;
        logic [2:0] f3;
        logic       f7, z, lt;
        logic [3:0] ex_state;
        logic [2:0] id_imm, ex_aluc;
        logic       ex_sign, ex_pcen;
        logic [1:0] ex_pcsrc;
    } vec_t;

    vec_t vt[40];
    int   nv = 0;

    task automatic add_vec(input logic [4:0] op, input logic [2:0] f3, input logic f7, z, lt,
                           input logic [3:0] st, input logic [2:0] imm, aluc,
                           input logic sg, pc, input logic [1:0] ps);
        vt[nv] = '{op, f3, f7, z, lt, st, imm, aluc, sg, pc, ps};
        nv++;
    endtask

    // Random-run state
    bit         r[64];
    int         cls, t, m0, lat, exp_ifc, exp_mr, exp_mw, exp_regw, exp_pcen;
    logic [1:0] exp_d2r;
    int         ifc, mr, mw, cm, regw, pcn;
    logic [1:0] got_d2r;
    logic       valid, taken;

    localparam logic [4:0] NOPS[4] = '{5'b00101, 5'b00011, 5'b11100, 5'b01011};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // ---------------- decode table ----------------
        add_vec(5'b01100, 3'b000, 1'b0, 0, 0, 4'd2, 3'b010, 3'b010, 1, 0, 2'b00);
        add_vec(5'b01100, 3'b000, 1'b1, 0, 0, 4'd2, 3'b010, 3'b110, 1, 0, 2'b00);
        add_vec(5'b01100, 3'b111, 1'b0, 0, 0, 4'd2, 3'b010, 3'b000, 1, 0, 2'b00);
        add_vec(5'b01100, 3'b110, 1'b0, 0, 0, 4'd2, 3'b010, 3'b001, 1, 0, 2'b00);
        add_vec(5'b01100, 3'b010, 1'b0, 0, 0, 4'd2, 3'b010, 3'b111, 1, 0, 2'b00);
        add_vec(5'b01100, 3'b011, 1'b0, 0, 0, 4'd2, 3'b010, 3'b111, 0, 0, 2'b00);
        add_vec(5'b01100, 3'b101, 1'b0, 0, 0, 4'd2, 3'b010, 3'b101, 1, 0, 2'b00);
        add_vec(5'b01100, 3'b100, 1'b0, 0, 0, 4'd2, 3'b010, 3'b011, 1, 0, 2'b00);
        add_vec(5'b01100, 3'b001, 1'b0, 0, 0, 4'd2, 3'b010, 3'b010, 1, 0, 2'b00);
        add_vec(5'b00100, 3'b000, 1'b0, 0, 0, 4'd3, 3'b010, 3'b010, 1, 0, 2'b00);
        add_vec(5'b00100, 3'b111, 1'b0, 0, 0, 4'd3, 3'b010, 3'b000, 1, 0, 2'b00);
        add_vec(5'b00100, 3'b110, 1'b0, 0, 0, 4'd3, 3'b010, 3'b001, 1, 0, 2'b00);
        add_vec(5'b00100, 3'b010, 1'b0, 0, 0, 4'd3, 3'b010, 3'b111, 1, 0, 2'b00);
        add_vec(5'b00100, 3'b011, 1'b0, 0, 0, 4'd3, 3'b010, 3'b111, 0, 0, 2'b00);
        add_vec(5'b00100, 3'b101, 1'b0, 0, 0, 4'd3, 3'b010, 3'b101, 1, 0, 2'b00);
        add_vec(5'b00100, 3'b100, 1'b0, 0, 0, 4'd3, 3'b010, 3'b011, 1, 0, 2'b00);
        add_vec(5'b00100, 3'b001, 1'b0, 0, 0, 4'd3, 3'b010, 3'b010, 1, 0, 2'b00);
        add_vec(5'b00000, 3'b010, 1'b0, 0, 0, 4'd4, 3'b010, 3'b010, 0, 0, 2'b00);
        add_vec(5'b01000, 3'b010, 1'b0, 0, 0, 4'd4, 3'b010, 3'b010, 0, 0, 2'b00);
        add_vec(5'b11000, 3'b000, 1'b0, 1, 0, 4'd9, 3'b010, 3'b110, 0, 1, 2'b01);
        add_vec(5'b11000, 3'b000, 1'b0, 0, 1, 4'd9, 3'b010, 3'b110, 0, 0, 2'b01);
        add_vec(5'b11000, 3'b001, 1'b0, 1, 0, 4'd9, 3'b010, 3'b110, 0, 0, 2'b01);
        add_vec(5'b11000, 3'b001, 1'b0, 0, 0, 4'd9, 3'b010, 3'b110, 0, 1, 2'b01);
        add_vec(5'b11000, 3'b100, 1'b0, 0, 1, 4'd9, 3'b010, 3'b111, 1, 1, 2'b01);
        add_vec(5'b11000, 3'b100, 1'b0, 1, 0, 4'd9, 3'b010, 3'b111, 1, 0, 2'b01);
        add_vec(5'b11000, 3'b010, 1'b0, 1, 1, 4'd9, 3'b010, 3'b000, 0, 0, 2'b01);
        add_vec(5'b11011, 3'b000, 1'b0, 0, 0, 4'd10, 3'b011, 3'b000, 0, 1, 2'b01);
        add_vec(5'b11001, 3'b000, 1'b0, 0, 0, 4'd11, 3'b010, 3'b010, 0, 1, 2'b00);
        add_vec(5'b01101, 3'b000, 1'b0, 0, 0, 4'd12, 3'b010, 3'b000, 0, 0, 2'b00);

        // Reset state while reset is low, before the first release.
        #1;
        check("reset_state", state, 4'd0);
        check("reset_memread", MemRead, 1'b0);
        check("reset_pcen", PCEN, 1'b0);

        for (int i = 0; i < nv; i++) begin
            do_reset();
            OPcode = vt[i].op; Fun3 = vt[i].f3; Fun7 = vt[i].f7;
            zero = vt[i].z; blt = vt[i].lt; MIO_ready = 1'b1;
            #1;
            check($sformatf("v%0d_if_state", i), state, 4'd0);
            check($sformatf("v%0d_if_irwrite", i), IRWrite, 1'b1);
            @(negedge clk); MIO_ready = 1'b0; #1;
            check($sformatf("v%0d_id_state", i), state, 4'd1);
            check($sformatf("v%0d_id_immsel", i), ImmSel, vt[i].id_imm);
            @(negedge clk); #1;
            check($sformatf("v%0d_ex_state", i), state, vt[i].ex_state);
            check($sformatf("v%0d_ex_aluc", i), ALUC, vt[i].ex_aluc);
            check($sformatf("v%0d_ex_sign", i), Sign, vt[i].ex_sign);
            check($sformatf("v%0d_ex_pcen", i), PCEN, vt[i].ex_pcen);
            check($sformatf("v%0d_ex_pcsrc", i), PCSource, vt[i].ex_pcsrc);
        end

        // ---------------- reset while in MEM_WR ----------------
        do_reset();
        OPcode = 5'b01000; Fun3 = 3'b010; MIO_ready = 1'b1;
        @(negedge clk); MIO_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("sw_memwr_state", state, 4'd6);
        check("sw_memwrite", MemWrite, 1'b1);
        check("sw_cpu_mio", CPU_MIO, 1'b1);
        reset = 1'b0; #1;
        check("rst_memwrite", MemWrite, 1'b0);
        check("rst_cpu_mio", CPU_MIO, 1'b0);
        check("rst_state", state, 4'd0);
        @(negedge clk); reset = 1'b1; MIO_ready = 1'b0; #1;
        check("post_rst_state", state, 4'd0);
        check("post_rst_memread", MemRead, 1'b1);
        check("post_rst_pcen", PCEN, 1'b0);
        @(negedge clk); #1;
        check("post_rst_hold", state, 4'd0);
        check("post_rst_pcen_hold", PCEN, 1'b0);
        MIO_ready = 1'b1; #1;
        check("post_rst_pcen_rdy", PCEN, 1'b1);

        // ---------------- R-type add sequence ----------------
        begin
            logic [3:0] st_e[5] = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd0};
            logic       rw_e[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            do_reset();
            OPcode = 5'b01100; Fun3 = 3'b000; Fun7 = 1'b0; MIO_ready = 1'b1;
            for (int c = 0; c < 5; c++) begin
                if (c > 0) @(negedge clk);
                MIO_ready = (c == 4) ? 1'b0 : 1'b1;
                #1;
                check($sformatf("add_state_c%0d", c), state, st_e[c]);
                check($sformatf("add_regwrite_c%0d", c), RegWrite, rw_e[c]);
                if (c == 2) check("add_aluc", ALUC, 3'b010);
                if (c == 3) check("add_d2r", DatatoReg, 2'b00);
            end
        end

        // ---------------- lw with 3 wait cycles in MEM_RD ----------------
        begin
            logic [3:0] st_e[9] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd8, 4'd0};
            bit         rd_e[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            do_reset();
            OPcode = 5'b00000; Fun3 = 3'b010;
            for (int c = 0; c < 9; c++) begin
                if (c > 0) @(negedge clk);
                MIO_ready = rd_e[c];
                #1;
                check($sformatf("lw_state_c%0d", c), state, st_e[c]);
                check($sformatf("lw_regwrite_c%0d", c), RegWrite, (c == 7) ? 1'b1 : 1'b0);
                if (c == 7) check("lw_d2r", DatatoReg, 2'b01);
                if (c >= 3 && c <= 6) check($sformatf("lw_iord_c%0d", c), IorD, 1'b1);
            end
        end

        // ---------------- jal then jalr ----------------
        do_reset();
        OPcode = 5'b11011; MIO_ready = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        check("jal_state", state, 4'd10);
        check("jal_pcen", PCEN, 1'b1);
        check("jal_regwrite", RegWrite, 1'b1);
        check("jal_d2r", DatatoReg, 2'b10);
        check("jal_pcsrc", PCSource, 2'b01);
        @(negedge clk); OPcode = 5'b11001; Fun3 = 3'b000; #1;
        check("jal_done_state", state, 4'd0);
        @(negedge clk); @(negedge clk); #1;
        check("jalr_state", state, 4'd11);
        check("jalr_pcen", PCEN, 1'b1);
        check("jalr_regwrite", RegWrite, 1'b1);
        check("jalr_d2r", DatatoReg, 2'b10);
        check("jalr_pcsrc", PCSource, 2'b00);
        @(negedge clk); #1;
        check("jalr_done_state", state, 4'd0);

`ifdef MC_PERF_CNT_EN
        do_reset();
        OPcode = 5'b01100; Fun3 = 3'b000; Fun7 = 1'b0; MIO_ready = 1'b1;
        #1;
        check("perf_cycle_reset", cycle_cnt, 32'd0);
        repeat (40) @(negedge clk);
        #1;
        check("perf_instret_10", instret_cnt, 32'd10);
        check("perf_cycle_40", cycle_cnt, 32'd40);
`endif

        // ---------------- randomized instructions vs. instruction-level model ----------------
        do_reset();
        for (int n = 0; n < 200; n++) begin
            cls = $urandom_range(0, 8);
            Fun3 = 3'($urandom_range(0, 7));
            Fun7 = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            blt  = 1'($urandom_range(0, 1));
            case (cls)
                0: OPcode = 5'b01100;
                1: OPcode = 5'b00100;
                2: OPcode = 5'b00000;
                3: OPcode = 5'b01000;
                4: OPcode = 5'b11000;
                5: OPcode = 5'b11011;
                6: OPcode = 5'b11001;
                7: OPcode = 5'b01101;
                default: OPcode = NOPS[$urandom_range(0, 3)];
            endcase
            for (int k = 0; k < 64; k++) r[k] = (k < 20) ? ($urandom_range(0, 2) != 0) : 1'b1;

            // Expected effects of this instruction
            valid = 1'b1;
            if (cls == 0) begin
                case ({Fun3, Fun7})
                    4'b0000, 4'b0001, 4'b1110, 4'b1100,
                    4'b0100, 4'b0110, 4'b1010, 4'b1000: valid = 1'b1;
                    default: valid = 1'b0;
                endcase
            end else if (cls == 1) begin
                valid = (Fun3 != 3'b001);
            end
            taken = (Fun3 == 3'b000) ? zero : (Fun3 == 3'b001) ? ~zero :
                    (Fun3 == 3'b100) ? blt : 1'b0;

            t = 0;
            while (!r[t]) t++;
            exp_ifc = t + 1;
            t = t + 2;
            exp_mr = exp_ifc;
            exp_mw = 0;
            case (cls)
                0, 1: t = t + 2;
                2: begin
                    t++; m0 = t;
                    while (!r[t]) t++;
                    exp_mr = exp_mr + (t - m0 + 1);
                    t = t + 2;
                end
                3: begin
                    t++; m0 = t;
                    while (!r[t]) t++;
                    exp_mw = t - m0 + 1;
                    t++;
                end
                4, 5, 6, 7: t++;
                default: ;
            endcase
            lat = t;
            exp_regw = ((cls <= 1 && valid) || cls == 2 || cls == 5 || cls == 6 || cls == 7) ? 1 : 0;
            exp_d2r = (cls == 2) ? 2'b01 : (cls == 5 || cls == 6) ? 2'b10 :
                      (cls == 7) ? 2'b11 : 2'b00;
            exp_pcen = 1 + (((cls == 4) && taken) || cls == 5 || cls == 6 ? 1 : 0);

            ifc = 0; mr = 0; mw = 0; cm = 0; regw = 0; pcn = 0; got_d2r = 2'b00;
            for (int c = 0; c < lat; c++) begin
                MIO_ready = r[c];
                #1;
                if (state == 4'd0) ifc++;
                if (MemRead) mr++;
                if (MemWrite) mw++;
                if (CPU_MIO) cm++;
                if (PCEN) pcn++;
                if (RegWrite) begin regw++; got_d2r = DatatoReg; end
                @(negedge clk);
            end
            check($sformatf("rnd%0d_op%0h_done", n, OPcode), state, 4'd0);
            check($sformatf("rnd%0d_if_cycles", n), ifc, exp_ifc);
            check($sformatf("rnd%0d_memread", n), mr, exp_mr);
            check($sformatf("rnd%0d_memwrite", n), mw, exp_mw);
            check($sformatf("rnd%0d_cpu_mio", n), cm, exp_mr + exp_mw);
            check($sformatf("rnd%0d_pcen", n), pcn, exp_pcen);
            check($sformatf("rnd%0d_regwrite", n), regw, exp_regw);
            if (exp_regw == 1) check($sformatf("rnd%0d_d2r", n), got_d2r, exp_d2r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
